ps2_scancode_queue: RTL

Buffers decoded PS/2 receive bytes between the receive shifter and the CPU-facing bus port. Each completed byte from the shifter is folded with any preceding E0/F0 prefix into one queue entry, then pushed into a power-of-two FIFO. The CPU drains entries through a status/scancode register pair. This replaces the single-byte holding register, so bursts of make/break codes are not lost while the CPU is busy.

---
 rtl/ps2_scancode_queue.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_queue.sv
// ps2_scancode_queue
//   Buffers decoded PS/2 receive bytes between the receive shifter and the
//   CPU bus port. Each good byte is folded with any pending E0/F0 prefix
//   into one entry {code[7:0], extended, release}. The entry is then pushed
//   into a FIFO with 2**DEPTH_LOG2 entries. The CPU drains the FIFO through
//   a status word and a scancode word.
//
//   Configuration macro: PS2_QUEUE_PREFIX_FOLD_EN
//     defined   - the prefix FSM folds E0/F0 into the extended/release bits
//     undefined - every good byte is pushed raw with extended=0, release=0
//
// Ports
//   clock              system clock; all state changes on the rising edge
//   reset_n            asynchronous active-low reset
//   rx_scancode[7:0]   byte from the receive shifter
//   scancode_ready_set one-cycle strobe: rx_scancode is complete
//   parity_error       marks the strobed byte as bad
//   read               bus read strobe
//   status_cs          selects the status word
//   scancode_cs        selects the head entry
//   data_out[31:0]     read data, combinational from the selects
//   data_out_valid     high whenever a select is active
//
// Status word   : {not_empty, overflow, parity_seen, 5'b0, count[7:0], 16'h0}
// Scancode word : {code[7:0], extended, release, 22'b0}, or 32'h0 when empty
//
// Prefix FSM (PS2_QUEUE_PREFIX_FOLD_EN only)
//   state     | meaning
//   IDLE      | no prefix pending
//   GOT_E0    | E0 seen; next code is extended
//   GOT_F0    | F0 seen; next byte is a release code
//   GOT_E0_F0 | E0 F0 seen; next byte is an extended release code

module ps2_scancode_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_scancode,
  input  logic        scancode_ready_set,
  input  logic        parity_error,
  input  logic        read,
  input  logic        status_cs,
  input  logic        scancode_cs,
  output logic [31:0] data_out,
  output logic        data_out_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic                  good_byte;
  logic                  bad_byte;
  logic                  push_req;
  logic [9:0]            push_entry;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  overflow_set;
  logic                  status_clear;

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [9:0]            mem [DEPTH];
  logic                  overflow;
  logic                  parity_seen;

  assign good_byte = scancode_ready_set & ~parity_error;
  assign bad_byte  = scancode_ready_set &  parity_error;

`ifdef PS2_QUEUE_PREFIX_FOLD_EN
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GOT_E0    = 2'd1,
    GOT_F0    = 2'd2,
    GOT_E0_F0 = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A full FIFO drops the entry later, but the FSM still completes the
  // sequence and returns to IDLE.
  always_comb begin
    state_nxt  = state;
    push_req   = 1'b0;
    push_entry = {rx_scancode, 2'b00};
    if (bad_byte) begin
      state_nxt = IDLE;
    end else if (good_byte) begin
      case (state)
        IDLE: begin
          if (rx_scancode == 8'hE0) begin
            state_nxt = GOT_E0;
          end else if (rx_scancode == 8'hF0) begin
            state_nxt = GOT_F0;
          end else begin
            push_req = 1'b1;
          end
        end
        GOT_E0: begin
          if (rx_scancode == 8'hF0) begin
            state_nxt = GOT_E0_F0;
          end else if (rx_scancode != 8'hE0) begin
            push_req   = 1'b1;
            push_entry = {rx_scancode, 2'b10};
            state_nxt  = IDLE;
          end
        end
        GOT_F0: begin
          push_req   = 1'b1;
          push_entry = {rx_scancode, 2'b01};
          state_nxt  = IDLE;
        end
        GOT_E0_F0: begin
          push_req   = 1'b1;
          push_entry = {rx_scancode, 2'b11};
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
`else
  assign push_req   = good_byte;
  assign push_entry = {rx_scancode, 2'b00};
`endif

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign pop          = read & scancode_cs & ~empty;
  assign push         = push_req & (~full | pop);
  assign overflow_set = push_req & full & ~pop;
  assign status_clear = read & status_cs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      parity_seen <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set events take priority over the status-read clear.
      if (overflow_set)      overflow <= 1'b1;
      else if (status_clear) overflow <= 1'b0;
      if (bad_byte)          parity_seen <= 1'b1;
      else if (status_clear) parity_seen <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Status has priority if both selects are active together.
  always_comb begin
    data_out = 32'h0;
    if (status_cs) begin
      data_out = {~empty, overflow, parity_seen, 5'b0, 8'(count), 16'h0};
    end else if (scancode_cs && !empty) begin
      data_out = {mem[rd_ptr], 22'b0};
    end
  end

  assign data_out_valid = status_cs | scancode_cs;

endmodule
